// File: rtl/ring_config_probe.sv
// Ring discovery: sends NUM_ROUNDS probe frames, times each round trip, captures the slave
// count and derives the average per-slave forwarding delay with a 16-cycle restoring divide.
`timescale 1ns / 1ps
module ring_config_probe #(
  parameter int unsigned ROUND_LOG2     = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000,
  parameter logic [15:0] MASTER_LAT     = 16'd20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       TxProbe,
  input  logic       RxValid,
  input  logic [7:0] RxSlaveID,
  output logic       Busy,
  output logic       Done,
  output logic       Timeout,
  output logic       Error,
  output logic [7:0] LastSlaveIDPlus1,
  output logic [7:0] AveSlaveDelay
);

  localparam int unsigned AccW      = 16 + ROUND_LOG2;
  localparam int unsigned RoundW    = ROUND_LOG2 + 1;
  localparam logic [RoundW-1:0] LastRound = RoundW'((1 << ROUND_LOG2) - 1);

  typedef enum logic [2:0] {StIdle, StSend, StWait, StAvg, StDiv, StFinish} state_e;

  state_e            state;
  logic [15:0]       cnt;
  logic [RoundW-1:0] round;
  logic [AccW-1:0]   acc;
  logic [15:0]       divRem;
  logic [15:0]       divQuo;
  logic [3:0]        divCnt;

  logic [15:0] avg;
  logic [15:0] dividend;
  logic [16:0] remShift;
  logic [16:0] remTrial;
  logic [15:0] remNext;
  logic [15:0] quoNext;

  // divQuo starts as the dividend and shifts its bits out while quotient bits shift in.
  always_comb begin
    avg      = 16'(acc >> ROUND_LOG2);
    dividend = (avg > MASTER_LAT) ? (avg - MASTER_LAT) : 16'd0;
    remShift = {divRem, divQuo[15]};
    remTrial = remShift - {9'd0, LastSlaveIDPlus1};
    if (remTrial[16]) begin
      remNext = remShift[15:0];
      quoNext = {divQuo[14:0], 1'b0};
    end else begin
      remNext = remTrial[15:0];
      quoNext = {divQuo[14:0], 1'b1};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state            <= StIdle;
      cnt              <= '0;
      round            <= '0;
      acc              <= '0;
      divRem           <= '0;
      divQuo           <= '0;
      divCnt           <= '0;
      TxProbe          <= 1'b0;
      Busy             <= 1'b0;
      Done             <= 1'b0;
      Timeout          <= 1'b0;
      Error            <= 1'b0;
      LastSlaveIDPlus1 <= '0;
      AveSlaveDelay    <= '0;
    end else begin
      TxProbe <= 1'b0;
      unique case (state)
        StIdle: begin
          if (Start) begin
            Done             <= 1'b0;
            Timeout          <= 1'b0;
            Error            <= 1'b0;
            LastSlaveIDPlus1 <= '0;
            AveSlaveDelay    <= '0;
            round            <= '0;
            acc              <= '0;
            Busy             <= 1'b1;
            TxProbe          <= 1'b1;
            state            <= StSend;
          end
        end
        StSend: begin
          cnt   <= 16'd1;
          state <= StWait;
        end
        StWait: begin
          // A frame arriving on the limit cycle still counts as received.
          if (RxValid) begin
            acc <= acc + AccW'(cnt);
            if (round == '0) begin
              LastSlaveIDPlus1 <= RxSlaveID;
            end else if (RxSlaveID != LastSlaveIDPlus1) begin
              Error <= 1'b1;
            end
            if (round == LastRound) begin
              state <= StAvg;
            end else begin
              round   <= round + RoundW'(1);
              TxProbe <= 1'b1;
              state   <= StSend;
            end
          end else if (cnt >= TIMEOUT_CYCLES) begin
            Timeout          <= 1'b1;
            LastSlaveIDPlus1 <= '0;
            AveSlaveDelay    <= '0;
            state            <= StFinish;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        StAvg: begin
          divRem <= '0;
          divQuo <= dividend;
          divCnt <= '0;
          if (LastSlaveIDPlus1 == 8'd0) begin
            AveSlaveDelay <= '0;
            state         <= StFinish;
          end else begin
            state <= StDiv;
          end
        end
        StDiv: begin
          divRem <= remNext;
          divQuo <= quoNext;
          divCnt <= divCnt + 4'd1;
          if (divCnt == 4'd15) begin
            AveSlaveDelay <= (quoNext > 16'd255) ? 8'hFF : quoNext[7:0];
            state         <= StFinish;
          end
        end
        StFinish: begin
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
